// File: rtl/isp_loader_pkg.sv
// Shared definitions for the ISP boot loader: FSM state encoding and stream framing constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package isp_loader_pkg;

   // Loader FSM states, in the order a normal load walks through them.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HDR     = 3'd1,
      DATA    = 3'd2,
      WRITE   = 3'd3,
      RELEASE = 3'd4,
      ERROR   = 3'd5
   } state_e;

   // The header is a 32-bit little-endian word count.
   localparam int HDR_BYTES         = 4;
   // Words on the host stream are 32 bits wide, LSB first.
   localparam int STREAM_WORD_WIDTH = 32;
   localparam int BYTES_PER_WORD    = STREAM_WORD_WIDTH / 8;

   // Bytes needed to build one instruction word of the given width.
   function automatic int bytes_per_word(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/byte_assembler.sv
// Shifts host bytes into a word, least significant byte first, and flags the byte that completes it.
// Latency: done_o/word_nxt_o are combinational with the completing byte; word_o holds the word from the next cycle.
// Backpressure: none; the parent only asserts take_i for bytes it has actually accepted.
//
// Ports:
//   clock_i, reset_ni   single clock, synchronous active-low reset
//   clear_i             drop any partial word and restart the byte count
//   take_i, byte_i      one accepted byte
//   word_o              registered assembled word
//   word_nxt_o          word including the byte being taken this cycle
//   done_o              this take_i completes a word
module byte_assembler
   import isp_loader_pkg::*;
#(
   parameter int NBYTES = BYTES_PER_WORD
) (
   input  logic                  clock_i,
   input  logic                  reset_ni,
   input  logic                  clear_i,
   input  logic                  take_i,
   input  logic [7:0]            byte_i,
   output logic [NBYTES*8-1:0]   word_o,
   output logic [NBYTES*8-1:0]   word_nxt_o,
   output logic                  done_o
);

   localparam int W     = NBYTES * 8;
   localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

   logic [W-1:0]     shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W+7:0]     cat;

   // New byte enters at the top; after NBYTES takes the first byte sits in bits [7:0].
   assign cat        = {byte_i, shift_q};
   assign word_nxt_o = cat[W+7:8];
   assign done_o     = take_i && (cnt_q == LAST);
   assign word_o     = shift_q;

   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (clear_i) begin
         shift_d = '0;
         cnt_d   = '0;
      end else if (take_i) begin
         shift_d = cat[W+7:8];
         cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock_i) begin
      if (!reset_ni) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/isp_boot_loader.sv
// Loads a length-prefixed image from a byte stream into instruction memory, holding the core in reset until done.
// Latency: one WRITE cycle after each completed word; RELEASE one cycle after the last write (or after a zero count).
// Backpressure: byte_ready_o is high only while collecting header/data bytes; stalls during WRITE, RELEASE, IDLE, ERROR.
//
// Ports:
//   clock_i, reset_ni          single clock, synchronous active-low reset (restarts in HDR)
//   load_req_i                 start a new load from IDLE or ERROR
//   byte_data_i/_valid_i/_ready_o  host byte stream, transfer when valid and ready
//   isp_address_o/_data_o/_write_o  one-cycle instruction-memory word write
//   core_reset_o, start_o      core hold and one-cycle PC-load pulse
//   program_address_o          byte address of the image (PROG_BASE<<2)
//   busy_o, error_o            load in progress / load failed
//   words_loaded_o             words written during this load
//   report_i                   print a status line on this clock edge
module isp_boot_loader
   import isp_loader_pkg::*;
#(
   parameter int CORE           = 0,
   parameter int DATA_WIDTH     = 32,
   parameter int ADDRESS_BITS   = 20,
   parameter int PROG_BASE      = 0,
   parameter int MAX_WORDS      = 4096,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                    clock_i,
   input  logic                    reset_ni,
   input  logic                    load_req_i,
   input  logic [7:0]              byte_data_i,
   input  logic                    byte_valid_i,
   output logic                    byte_ready_o,
   output logic [ADDRESS_BITS-1:0] isp_address_o,
   output logic [DATA_WIDTH-1:0]   isp_data_o,
   output logic                    isp_write_o,
   output logic                    core_reset_o,
   output logic                    start_o,
   output logic [ADDRESS_BITS-1:0] program_address_o,
   output logic                    busy_o,
   output logic                    error_o,
   output logic [ADDRESS_BITS-1:0] words_loaded_o,
   input  logic                    report_i
);

   localparam int GAP_W      = $clog2(TIMEOUT_CYCLES + 1);
   localparam int WORD_BYTES = bytes_per_word(DATA_WIDTH);
   localparam logic [GAP_W-1:0]        GAP_LIMIT = GAP_W'(TIMEOUT_CYCLES);
   localparam logic [31:0]             MAX_N     = 32'(MAX_WORDS);
   localparam logic [ADDRESS_BITS-1:0] BASE_ADDR = ADDRESS_BITS'(PROG_BASE);

   state_e                  state_q, state_d;
   logic [31:0]             index_q, index_d;
   logic [31:0]             n_q, n_d;
   logic [ADDRESS_BITS-1:0] words_q, words_d;
   logic [GAP_W-1:0]        gap_q, gap_d;
   logic                    started_q, started_d;

   logic                    accept;
   logic                    timeout;
   logic                    asm_clear;
   logic                    asm_done;
   logic [DATA_WIDTH-1:0]   asm_word;
   logic [DATA_WIDTH-1:0]   asm_word_nxt;
   logic [31:0]             hdr_count;

   // Header and data words share one assembler: both are 4 bytes, LSB first.
   byte_assembler #(
      .NBYTES (WORD_BYTES)
   ) u_asm (
      .clock_i    (clock_i),
      .reset_ni   (reset_ni),
      .clear_i    (asm_clear),
      .take_i     (accept),
      .byte_i     (byte_data_i),
      .word_o     (asm_word),
      .word_nxt_o (asm_word_nxt),
      .done_o     (asm_done)
   );

   assign byte_ready_o      = (state_q == HDR) || (state_q == DATA);
   assign accept            = byte_valid_i && byte_ready_o;
   assign hdr_count         = asm_word_nxt[HDR_BYTES*8-1:0];
   assign isp_address_o     = BASE_ADDR + index_q[ADDRESS_BITS-1:0];
   assign isp_data_o        = asm_word;
   assign program_address_o = ADDRESS_BITS'(PROG_BASE << 2);
   assign words_loaded_o    = words_q;

   always_comb begin
      state_d      = state_q;
      index_d      = index_q;
      n_d          = n_q;
      words_d      = words_q;
      gap_d        = gap_q;
      started_d    = started_q;
      asm_clear    = 1'b0;
      timeout      = 1'b0;
      isp_write_o  = 1'b0;
      core_reset_o = 1'b0;
      start_o      = 1'b0;
      busy_o       = 1'b0;
      error_o      = 1'b0;

      // Idle-gap watchdog: armed by the first byte of a load, cleared by every byte.
      if (accept) begin
         gap_d     = '0;
         started_d = 1'b1;
      end else if (byte_ready_o && started_q) begin
         gap_d   = gap_q + GAP_W'(1);
         timeout = (gap_d == GAP_LIMIT);
      end

      case (state_q)
         IDLE: begin
            if (load_req_i) begin
               state_d   = HDR;
               index_d   = '0;
               words_d   = '0;
               gap_d     = '0;
               started_d = 1'b0;
               asm_clear = 1'b1;
            end
         end
         HDR: begin
            core_reset_o = 1'b1;
            busy_o       = 1'b1;
            if (timeout) begin
               state_d   = ERROR;
               asm_clear = 1'b1;
            end else if (asm_done) begin
               n_d = hdr_count;
               if (hdr_count == 32'd0) begin
                  state_d = RELEASE;
               end else if (hdr_count > MAX_N) begin
                  state_d = ERROR;
               end else begin
                  state_d = DATA;
                  index_d = '0;
               end
            end
         end
         DATA: begin
            core_reset_o = 1'b1;
            busy_o       = 1'b1;
            if (timeout) begin
               state_d   = ERROR;
               asm_clear = 1'b1;
            end else if (asm_done) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            core_reset_o = 1'b1;
            busy_o       = 1'b1;
            // Suppress the strobe in a cycle where reset is being applied.
            isp_write_o  = reset_ni;
            index_d      = index_q + 32'd1;
            words_d      = words_q + ADDRESS_BITS'(1);
            state_d      = (index_q + 32'd1 < n_q) ? DATA : RELEASE;
         end
         RELEASE: begin
            start_o = 1'b1;
            state_d = IDLE;
         end
         ERROR: begin
            core_reset_o = 1'b1;
            error_o      = 1'b1;
            if (load_req_i) begin
               state_d   = HDR;
               index_d   = '0;
               words_d   = '0;
               gap_d     = '0;
               started_d = 1'b0;
               asm_clear = 1'b1;
            end
         end
         default: state_d = HDR;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (!reset_ni) begin
         state_q   <= HDR;
         index_q   <= '0;
         n_q       <= '0;
         words_q   <= '0;
         gap_q     <= '0;
         started_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         index_q   <= index_d;
         n_q       <= n_d;
         words_q   <= words_d;
         gap_q     <= gap_d;
         started_q <= started_d;
      end
   end

`ifndef SYNTHESIS
   always @(posedge clock_i) begin
      if (report_i) begin
         $display("isp_boot_loader core %0d: state=%s index=%0d n=%0d words_loaded=%0d error=%0b",
                  CORE, state_q.name(), index_q, n_q, words_q, error_o);
      end
   end
`endif

endmodule

// File: tb/tb_isp_boot_loader.sv
// Self-checking bench for isp_boot_loader: scenario tasks against a queue-based image model.
// Latency: n/a.
// Backpressure: byte sender waits on byte_ready with a bounded cycle budget.
module tb_isp_boot_loader;

   localparam int AW   = 20;
   localparam int DW   = 32;
   localparam int TMO  = 16;
   localparam int MAXW = 4096;
   localparam int BASE = 0;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          load_req = 1'b0;
   logic          byte_valid = 1'b0;
   logic          report = 1'b0;
   logic [7:0]    byte_data = 8'h00;
   logic          byte_ready, isp_write, core_reset, start, busy, error;
   logic [AW-1:0] isp_address, program_address, words_loaded;
   logic [DW-1:0] isp_data;

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;
   logic [AW+DW-1:0] obs_q[$];

   always #5 clk = ~clk;

   isp_boot_loader #(
      .CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AW), .PROG_BASE(BASE),
      .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clock_i(clk), .reset_ni(rst_n), .load_req_i(load_req),
      .byte_data_i(byte_data), .byte_valid_i(byte_valid), .byte_ready_o(byte_ready),
      .isp_address_o(isp_address), .isp_data_o(isp_data), .isp_write_o(isp_write),
      .core_reset_o(core_reset), .start_o(start), .program_address_o(program_address),
      .busy_o(busy), .error_o(error), .words_loaded_o(words_loaded), .report_i(report)
   );

   // Record every memory write and start pulse, sampled mid-cycle.
   always @(negedge clk) begin
      if (isp_write === 1'b1) obs_q.push_back({isp_address, isp_data});
      if (start === 1'b1) start_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit rnd);
      int n;
      n = 0;
      if (rnd) begin
         while ($urandom_range(1, 0) == 1 && n < 6) begin
            tick();
            n++;
         end
      end
      byte_data  = b;
      byte_valid = 1'b1;
      n = 0;
      while (byte_ready !== 1'b1 && n < 64) begin
         tick();
         n++;
      end
      if (n >= 64) begin
         errors++;
         $display("FAIL send_byte_ready got byte_ready=%b required 1", byte_ready);
      end
      tick();
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
   endtask

   task automatic send_word(input logic [31:0] w, input bit rnd);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], rnd);
   endtask

   task automatic pulse_load_req();
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
   endtask

   task automatic wait_start(input int sbase, input string name);
      int n;
      n = 0;
      while (start_cnt == sbase && n < 60) begin
         tick();
         n++;
      end
      tick();
      tick();
      checks++;
      if (start_cnt - sbase !== 1) begin
         errors++;
         $display("FAIL %s_start_pulses got %0d required 1", name, start_cnt - sbase);
      end
   endtask

   task automatic test_reset();
      logic [AW-1:0] pa;
      pa = AW'(BASE << 2);
      rst_n = 1'b0;
      load_req = 1'b1;
      byte_valid = 1'b1;
      byte_data = 8'hFF;
      tick();
      tick();
      load_req = 1'b0;
      byte_valid = 1'b0;
      rst_n = 1'b1;
      checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL rst_core_reset got %b required 1", core_reset); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b required 1", busy); end
      checks++; if (start !== 1'b0) begin errors++; $display("FAIL rst_start got %b required 0", start); end
      checks++; if (isp_write !== 1'b0) begin errors++; $display("FAIL rst_isp_write got %b required 0", isp_write); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error got %b required 0", error); end
      checks++; if (words_loaded !== '0) begin errors++; $display("FAIL rst_words_loaded got %0d required 0", words_loaded); end
      checks++; if (isp_address !== AW'(BASE)) begin errors++; $display("FAIL rst_isp_address got %h required %h", isp_address, AW'(BASE)); end
      checks++; if (isp_data !== '0) begin errors++; $display("FAIL rst_isp_data got %h required 0", isp_data); end
      checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL rst_byte_ready got %b required 1", byte_ready); end
      checks++; if (program_address !== pa) begin errors++; $display("FAIL rst_program_address got %h required %h", program_address, pa); end
   endtask

   task automatic test_basic_load();
      int base, sbase;
      logic [31:0] img[2];
      logic [AW+DW-1:0] exp_w, got_w;
      img[0] = 32'h0000_0013;
      img[1] = 32'h0000_006F;
      base  = obs_q.size();
      sbase = start_cnt;
      send_word(32'd2, 1'b0);
      checks++; if (core_reset !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL basic_midload got core_reset=%b busy=%b required 1 1", core_reset, busy); end
      for (int i = 0; i < 2; i++) send_word(img[i], 1'b0);
      wait_start(sbase, "basic");
      checks++; if (obs_q.size() - base !== 2) begin errors++; $display("FAIL basic_write_count got %0d required 2", obs_q.size() - base); end
      for (int i = 0; i < 2; i++) begin
         exp_w = {AW'(BASE + i), img[i]};
         got_w = (base + i < obs_q.size()) ? obs_q[base + i] : 'x;
         checks++; if (got_w !== exp_w) begin errors++; $display("FAIL basic_write%0d got %h required %h", i, got_w, exp_w); end
      end
      checks++; if (core_reset !== 1'b0) begin errors++; $display("FAIL basic_core_reset got %b required 0", core_reset); end
      checks++; if (busy !== 1'b0 || byte_ready !== 1'b0) begin errors++; $display("FAIL basic_idle got busy=%b ready=%b required 0 0", busy, byte_ready); end
      checks++; if (words_loaded !== AW'(2)) begin errors++; $display("FAIL basic_words_loaded got %0d required 2", words_loaded); end
      report = 1'b1;
      tick();
      report = 1'b0;
   endtask

   task automatic test_zero_count();
      int base;
      base = obs_q.size();
      // Byte presented together with load_req must not be taken.
      load_req = 1'b1;
      byte_valid = 1'b1;
      byte_data = 8'hAA;
      tick();
      load_req = 1'b0;
      byte_valid = 1'b0;
      checks++; if (core_reset !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL zero_enter_hdr got core_reset=%b busy=%b required 1 1", core_reset, busy); end
      checks++; if (words_loaded !== '0) begin errors++; $display("FAIL zero_words_cleared got %0d required 0", words_loaded); end
      send_word(32'd0, 1'b0);
      checks++; if (start !== 1'b1 || core_reset !== 1'b0) begin errors++; $display("FAIL zero_release got start=%b core_reset=%b required 1 0", start, core_reset); end
      tick();
      checks++; if (start !== 1'b0) begin errors++; $display("FAIL zero_start_width got %b required 0", start); end
      checks++; if (obs_q.size() !== base) begin errors++; $display("FAIL zero_no_write got %0d writes required 0", obs_q.size() - base); end
   endtask

   task automatic test_too_big();
      int base;
      bit bad;
      base = obs_q.size();
      pulse_load_req();
      send_word(32'(MAXW + 1), 1'b0);
      checks++; if (error !== 1'b1 || core_reset !== 1'b1) begin errors++; $display("FAIL big_error got error=%b core_reset=%b required 1 1", error, core_reset); end
      checks++; if (busy !== 1'b0 || byte_ready !== 1'b0) begin errors++; $display("FAIL big_flags got busy=%b ready=%b required 0 0", busy, byte_ready); end
      for (int i = 0; i < 5; i++) tick();
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL big_error_hold got %b required 1", error); end
      checks++; if (obs_q.size() !== base) begin errors++; $display("FAIL big_no_write got %0d writes required 0", obs_q.size() - base); end
      pulse_load_req();
      checks++; if (error !== 1'b0 || busy !== 1'b1 || byte_ready !== 1'b1) begin errors++; $display("FAIL big_reload got error=%b busy=%b ready=%b required 0 1 1", error, busy, byte_ready); end
      // No bytes yet: the idle-gap watchdog must stay disarmed.
      bad = 1'b0;
      for (int i = 0; i < 2 * TMO; i++) begin
         tick();
         if (error !== 1'b0) bad = 1'b1;
      end
      checks++; if (bad) begin errors++; $display("FAIL big_no_early_timeout got error=1 required 0"); end
   endtask

   task automatic test_timeout();
      int base;
      bit bad;
      base = obs_q.size();
      send_word(32'(MAXW), 1'b0);
      checks++; if (error !== 1'b0 || busy !== 1'b1 || byte_ready !== 1'b1) begin errors++; $display("FAIL tmo_max_accepted got error=%b busy=%b ready=%b required 0 1 1", error, busy, byte_ready); end
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      bad = 1'b0;
      for (int i = 1; i < TMO; i++) begin
         tick();
         if (error !== 1'b0) bad = 1'b1;
      end
      checks++; if (bad) begin errors++; $display("FAIL tmo_early got error=1 before gap %0d required 0", TMO); end
      tick();
      checks++; if (error !== 1'b1 || core_reset !== 1'b1) begin errors++; $display("FAIL tmo_error got error=%b core_reset=%b required 1 1", error, core_reset); end
      checks++; if (obs_q.size() !== base) begin errors++; $display("FAIL tmo_no_write got %0d writes required 0", obs_q.size() - base); end
   endtask

   task automatic test_random_valid();
      int base, sbase;
      logic [31:0] img[8];
      logic [AW+DW-1:0] exp_w, got_w;
      pulse_load_req();
      for (int i = 0; i < 8; i++) img[i] = $urandom;
      base  = obs_q.size();
      sbase = start_cnt;
      send_word(32'd8, 1'b1);
      for (int i = 0; i < 8; i++) send_word(img[i], 1'b1);
      wait_start(sbase, "rand");
      checks++; if (obs_q.size() - base !== 8) begin errors++; $display("FAIL rand_write_count got %0d required 8", obs_q.size() - base); end
      for (int i = 0; i < 8; i++) begin
         exp_w = {AW'(BASE + i), img[i]};
         got_w = (base + i < obs_q.size()) ? obs_q[base + i] : 'x;
         checks++; if (got_w !== exp_w) begin errors++; $display("FAIL rand_write%0d got %h required %h", i, got_w, exp_w); end
      end
      checks++; if (words_loaded !== AW'(8)) begin errors++; $display("FAIL rand_words_loaded got %0d required 8", words_loaded); end
   endtask

   task automatic test_reset_mid_load();
      int base, sbase;
      logic [31:0] img[5];
      logic [AW+DW-1:0] exp_w, got_w;
      for (int i = 0; i < 5; i++) img[i] = $urandom;
      pulse_load_req();
      base = obs_q.size();
      send_word(32'd5, 1'b0);
      for (int i = 0; i < 3; i++) send_word(img[i], 1'b0);
      send_byte(img[3][7:0], 1'b0);
      send_byte(img[3][15:8], 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++; if (busy !== 1'b1 || core_reset !== 1'b1 || words_loaded !== '0) begin errors++; $display("FAIL mid_reset_state got busy=%b core_reset=%b words=%0d required 1 1 0", busy, core_reset, words_loaded); end
      for (int i = 0; i < 10; i++) tick();
      checks++; if (obs_q.size() - base !== 3) begin errors++; $display("FAIL mid_write_count got %0d required 3", obs_q.size() - base); end
      for (int i = 0; i < 3; i++) begin
         exp_w = {AW'(BASE + i), img[i]};
         got_w = (base + i < obs_q.size()) ? obs_q[base + i] : 'x;
         checks++; if (got_w !== exp_w) begin errors++; $display("FAIL mid_write%0d got %h required %h", i, got_w, exp_w); end
      end
      // Full reload straight from HDR after reset.
      for (int i = 0; i < 3; i++) img[i] = $urandom;
      base  = obs_q.size();
      sbase = start_cnt;
      send_word(32'd3, 1'b1);
      for (int i = 0; i < 3; i++) send_word(img[i], 1'b1);
      wait_start(sbase, "reload");
      checks++; if (obs_q.size() - base !== 3) begin errors++; $display("FAIL reload_write_count got %0d required 3", obs_q.size() - base); end
      for (int i = 0; i < 3; i++) begin
         exp_w = {AW'(BASE + i), img[i]};
         got_w = (base + i < obs_q.size()) ? obs_q[base + i] : 'x;
         checks++; if (got_w !== exp_w) begin errors++; $display("FAIL reload_write%0d got %h required %h", i, got_w, exp_w); end
      end
      checks++; if (words_loaded !== AW'(3) || error !== 1'b0) begin errors++; $display("FAIL reload_final got words=%0d error=%b required 3 0", words_loaded, error); end
   endtask

   initial begin
      #1;
      test_reset();
      test_basic_load();
      test_zero_count();
      test_too_big();
      test_timeout();
      test_random_valid();
      test_reset_mid_load();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got no completion required finish within 400000 time units");
      $fatal(1);
   end

endmodule

// File: doc/isp_boot_loader.md
ISP_BOOT_LOADER -- requirements
Module: isp_boot_loader

Interface
REQ-001 Parameters SHALL be: CORE, 0, core id for reports; DATA_WIDTH, 32, instruction word width; ADDRESS_BITS, 20, instruction-memory address width; PROG_BASE, 0, first word address written; MAX_WORDS, 4096, largest legal image; TIMEOUT_CYCLES, 1000000, maximum idle gap between bytes once a load has begun.
REQ-002 Ports SHALL be: clock in 1, single clock; reset in 1, synchronous active-low; load_req in 1, request reload; byte_data in 8, host byte; byte_valid in 1, byte present; byte_ready out 1, byte accepted when both high; isp_address out ADDRESS_BITS, word write address; isp_data out DATA_WIDTH, word to write; isp_write out 1, one-cycle write strobe; core_reset out 1, active-high hold for the core; start out 1, one-cycle PC-load pulse; program_address out ADDRESS_BITS, byte address PROG_BASE<<2; busy out 1, load in progress; error out 1, load failed; words_loaded out ADDRESS_BITS, words written this load; report in 1, print status.

Function
REQ-003 States SHALL be IDLE, HDR, DATA, WRITE, RELEASE, ERROR.
REQ-004 The byte stream SHALL be a 4-byte little-endian word count N, then N words each sent as 4 bytes, least significant byte first.
REQ-005 byte_ready SHALL be 1 only in HDR and DATA, and 0 in all other states.
REQ-006 In HDR, the block SHALL collect 4 bytes, then:
- N==0: go to RELEASE.
- N>MAX_WORDS: go to ERROR.
- otherwise: go to DATA with the word index cleared to 0.
REQ-007 In DATA, after the 4th accepted byte the block SHALL go to WRITE.
REQ-008 WRITE SHALL last exactly 1 cycle with isp_write=1, isp_address=PROG_BASE+index (truncated to ADDRESS_BITS) and isp_data=the assembled word; index and words_loaded SHALL then increment.
REQ-009 After WRITE, the block SHALL return to DATA if index<N, otherwise go to RELEASE.
REQ-010 RELEASE SHALL last 1 cycle with core_reset=0 and start=1, then go to IDLE.
REQ-011 In IDLE, core_reset=0, start=0 and busy=0.
REQ-012 core_reset SHALL be 1 and busy SHALL be 1 in HDR, DATA and WRITE; in ERROR core_reset SHALL be 1 and busy SHALL be 0.
REQ-013 The gap counter SHALL clear on every accepted byte and on entry to HDR.
- It SHALL count only in HDR/DATA after the first byte of a load has been accepted.
- When it reaches TIMEOUT_CYCLES, the block SHALL go to ERROR and discard any partial word.
REQ-014 ERROR SHALL hold error=1 until load_req; load_req in ERROR SHALL go to HDR and clear error.
REQ-015 load_req in IDLE SHALL go to HDR, assert core_reset the next cycle, and clear words_loaded.
REQ-016 load_req SHALL be ignored in HDR, DATA, WRITE and RELEASE.
REQ-017 If load_req and byte_valid are both high in IDLE, the byte SHALL NOT be accepted.
REQ-018 program_address SHALL be constant (PROG_BASE<<2, truncated).
REQ-019 Write-address wrap past 2^ADDRESS_BITS-1 SHALL wrap to 0; no error is raised.
REQ-020 When report=1 on a clock edge, the block SHALL $display CORE, state, index, N, words_loaded and error.

Reset
REQ-021 On reset==0 at a clock edge, the block SHALL enter HDR with:
- core_reset=1, busy=1;
- start, isp_write, error, words_loaded, index, the gap counter and the byte counter all 0;
- isp_address=PROG_BASE, isp_data=0.
REQ-022 Reset SHALL take precedence over all other inputs.
REQ-023 Reset asserted mid-load SHALL discard the partial image and restart in HDR; no isp_write SHALL issue in the cycle reset is asserted.

Structure
REQ-024 A package isp_loader_pkg SHALL hold the state encoding, HDR_BYTES=4 and BYTES_PER_WORD=DATA_WIDTH/8.
REQ-025 One sub-module, byte_assembler, SHALL shift in bytes LSB-first and flag word completion; all other logic SHALL be in isp_boot_loader.

Verification
REQ-026 The bench SHALL cover these scenarios:
- Reset, stream 02 00 00 00 / 13 00 00 00 / 6F 00 00 00 -> isp_write at addresses 0 and 1 with data 0x00000013 and 0x0000006F; one start pulse; core_reset falls; words_loaded=2.
- Count 00 00 00 00 -> no isp_write; RELEASE one cycle after the 4th byte.
- Count MAX_WORDS+1 -> ERROR, error=1, core_reset=1; load_req -> HDR, error=0.
- TIMEOUT_CYCLES=16; stop after byte 2 of word 0 -> ERROR at gap cycle 16; no write.
- byte_valid toggled randomly (50%) for 8 words -> image identical, with exactly 8 isp_write pulses.
- Reset pulsed after 3 words in DATA -> HDR, no further writes; a full reload then succeeds.
